mem_fifo_ctrl: RTL and testbench

Stream-to-memory controller that sits directly upstream of the 16x8 resettable memory and drives its `addr`/`data_in` pins while consuming its combinational `data_out`. It turns that single-port memory into a FIFO: an input valid/ready stream is written at an incrementing write pointer, and entries are read back in order into a registered output stage. The memory writes `mem[addr] <= data_in` on every clock, so this block must write back the current contents on every non-write cycle.

---
 rtl/mem_fifo_pkg.sv | 15 +
 rtl/mem_fifo_arb.sv | 62 ++++++
 rtl/mem_fifo_ctrl.sv | 96 +++++++++
 tb/tb_mem_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fifo_pkg.sv
// Shared types and default sizes for the memory-backed FIFO controller.
// Optional feature macro used by this slice: MEM_FIFO_FLUSH_EN.
package mem_fifo_pkg;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    OP_NOP,
    OP_WR,
    OP_RD
  } mem_op_t;

endpackage

// File: rtl/mem_fifo_arb.sv
// Combinational per-cycle operation select for the single-port memory.
// Reads win over writes; non-write cycles write back the current contents.
// With MEM_FIFO_FLUSH_EN defined, an active flush forces NOP and blocks input.
module mem_fifo_arb
  import mem_fifo_pkg::*;
#(
  parameter int AW = mem_fifo_pkg::AW,
  parameter int DW = mem_fifo_pkg::DW
) (
`ifdef MEM_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  input  logic [AW:0]   count,
  input  logic          in_valid,
  input  logic          out_valid,
  input  logic          out_ready,
  input  logic [AW-1:0] wr_ptr,
  input  logic [AW-1:0] rd_ptr,
  input  logic [DW-1:0] in_data,
  input  logic [DW-1:0] mem_rdata,
  output mem_op_t       op,
  output logic          in_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic flush_active;
  logic is_empty;
  logic is_full;
  logic slot_free;

`ifdef MEM_FIFO_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  assign is_empty  = (count == '0);
  assign is_full   = (count == FULL);
  assign slot_free = !out_valid || out_ready;

  // Pick RD, then WR, then NOP; the address and write data follow the choice
  always_comb begin
    op        = OP_NOP;
    mem_addr  = rd_ptr;
    mem_wdata = mem_rdata;
    in_ready  = 1'b0;
    if (!flush_active) begin
      if (!is_empty && slot_free) begin
        op = OP_RD;
      end else if (in_valid && !is_full) begin
        op        = OP_WR;
        mem_addr  = wr_ptr;
        mem_wdata = in_data;
      end
      in_ready = !is_full && (op != OP_RD);
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// Stream-to-memory FIFO controller driving an external 16x8 single-port memory.
// Holds the pointers, the occupancy count and the registered output stage.
// Optional macro MEM_FIFO_FLUSH_EN adds a synchronous flush input.
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int AW = mem_fifo_pkg::AW,
  parameter int DW = mem_fifo_pkg::DW
) (
  input  logic          clock,
  input  logic          reset,
`ifdef MEM_FIFO_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   count
);

  mem_op_t       op;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          out_valid_q;
  logic          flush_active;

`ifdef MEM_FIFO_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  // Downstream never sees a token while a flush is discarding it
  assign out_valid = out_valid_q && !flush_active;

  mem_fifo_arb #(
    .AW(AW),
    .DW(DW)
  ) u_arb (
`ifdef MEM_FIFO_FLUSH_EN
    .flush     (flush),
`endif
    .count     (count),
    .in_valid  (in_valid),
    .out_valid (out_valid_q),
    .out_ready (out_ready),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .in_data   (in_data),
    .mem_rdata (mem_rdata),
    .op        (op),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  // Advance pointers, count and output register according to the chosen op
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      out_data    <= '0;
    end else if (flush_active) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (op)
        OP_RD: begin
          out_data    <= mem_rdata;
          out_valid_q <= 1'b1;
          rd_ptr      <= rd_ptr + AW'(1);
          count       <= count - (AW + 1)'(1);
        end
        OP_WR: begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + (AW + 1)'(1);
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;
        end
        default: begin
          if (out_valid_q && out_ready) out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// Self-checking bench for mem_fifo_ctrl attached to a 16x8 resettable memory.
// Accepted tokens are queued as expectations; a monitor checks each output.
// Define MEM_FIFO_FLUSH_EN to also exercise the flush input.
module tb_mem_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [4:0] count;
`ifdef MEM_FIFO_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int         testsRun = 0;
  int         testsFailed = 0;
  logic [7:0] expQ[$];
  logic [7:0] mem[16];

  always #5 clock = ~clock;

  // Model of the existing 16x8 memory: writes every clock, async clear, comb read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  mem_fifo_ctrl dut (
    .clock     (clock),
    .reset     (reset),
`ifdef MEM_FIFO_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .count     (count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, record an acceptance, advance past the edge
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, output logic acc);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    acc = v && in_ready && reset;
    if (acc) expQ.push_back(d);
    @(posedge clock);
    #1;
  endtask

  // Every token the DUT hands downstream must be the oldest expected one
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL out_unexpected: got 0x%0h, expected no token", out_data);
      end else begin
        checkOutput("out_data", {24'h0, out_data}, {24'h0, expQ.pop_front()});
      end
    end
  end

  initial begin
    logic acc;
    int   n;
    int   numAcc;
    logic [7:0] d;

    // Reset values while reset is held low
    #12;
    checkOutput("rst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("rst_count", {27'h0, count}, 32'h0);
    checkOutput("rst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("rst_mem_addr", {28'h0, mem_addr}, 32'h0);
    checkOutput("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    #5 reset = 1'b1;
    @(posedge clock);
    #1;

    // Single token: write, then read into output register, then consumed
    applyStimulus(1'b1, 8'h5A, 1'b1, acc);
    checkOutput("single_accepted", {31'h0, acc}, 32'h1);
    checkOutput("single_count_after_wr", {27'h0, count}, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("single_out_valid", {31'h0, out_valid}, 32'h1);
    checkOutput("single_out_data", {24'h0, out_data}, 32'h5A);
    checkOutput("single_count", {27'h0, count}, 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("single_out_cleared", {31'h0, out_valid}, 32'h0);

    // Fill with downstream stalled: 17 tokens fit
    d = 8'h00;
    numAcc = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, d, 1'b0, acc);
      if (acc) begin
        numAcc++;
        d++;
      end
    end
    checkOutput("fill_accepted", numAcc, 32'd17);
    checkOutput("fill_count", {27'h0, count}, 32'd16);
    checkOutput("fill_in_ready", {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("drain_count", {27'h0, count}, 32'h0);
    checkOutput("drain_queue_empty", expQ.size(), 32'h0);

    // Random handshakes with incrementing data, crossing pointer wrap many times
    d = 8'h00;
    numAcc = 0;
    n = 0;
    while (numAcc < 200 && n < 5000) begin
      applyStimulus(1'($urandom_range(0, 1)), d, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        numAcc++;
        d++;
      end
      n++;
    end
    checkOutput("wrap_sent", numAcc, 32'd200);
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("wrap_queue_empty", expQ.size(), 32'h0);
    checkOutput("wrap_count", {27'h0, count}, 32'h0);

    // Load 5 tokens, idle with write-back, then drain intact
    d = 8'hC0;
    numAcc = 0;
    n = 0;
    while (numAcc < 5 && n < 50) begin
      applyStimulus(1'b1, d, 1'b0, acc);
      if (acc) begin
        numAcc++;
        d++;
      end
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, acc);
      checkOutput("hold_writeback", {24'h0, mem_wdata}, {24'h0, mem_rdata});
    end
    checkOutput("hold_count", {27'h0, count}, 32'd4);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("hold_queue_empty", expQ.size(), 32'h0);

    // Reset mid-stream with 9 entries in memory
    d = 8'h30;
    n = 0;
    while (count != 5'd9 && n < 50) begin
      applyStimulus(1'b1, d, 1'b0, acc);
      if (acc) d++;
      n++;
    end
    checkOutput("midrst_count_before", {27'h0, count}, 32'd9);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("midrst_count", {27'h0, count}, 32'h0);
    checkOutput("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    checkOutput("midrst_out_data", {24'h0, out_data}, 32'h0);
    checkOutput("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    checkOutput("midrst_mem_addr", {28'h0, mem_addr}, 32'h0);
    expQ.delete();
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(1'b1, 8'hA5, 1'b1, acc);
    applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("midrst_fresh_data", {24'h0, out_data}, 32'hA5);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("midrst_queue_empty", expQ.size(), 32'h0);

`ifdef MEM_FIFO_FLUSH_EN
    // Flush with 9 entries: pointers and output register clear on the edge
    d = 8'h60;
    n = 0;
    while (count != 5'd9 && n < 50) begin
      applyStimulus(1'b1, d, 1'b0, acc);
      if (acc) d++;
      n++;
    end
    flush = 1'b1;
    in_valid = 1'b1;
    #1;
    checkOutput("flush_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clock);
    #1;
    checkOutput("flush_count", {27'h0, count}, 32'h0);
    checkOutput("flush_out_valid", {31'h0, out_valid}, 32'h0);
    expQ.delete();
    flush = 1'b0;
    applyStimulus(1'b1, 8'hA5, 1'b1, acc);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, acc);
    checkOutput("flush_queue_empty", expQ.size(), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
